// File: rtl/mips_pipe_pkg.sv
// Shared encodings for the MIPS pipeline: forwarding-select codes, the zero
// register number, ALU operation codes and a destination/source hit helper.
package mips_pipe_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EXE = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int         ALU_OPW  = 4;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_NOR = 4'd5,
        ALU_SLT = 4'd6,
        ALU_SLL = 4'd7,
        ALU_SRL = 4'd8,
        ALU_SRA = 4'd9,
        ALU_LUI = 4'd10
    } alu_op_e;

    // $0 is never a real producer, so it can never create a dependency.
    function automatic logic reg_hit(input logic [4:0] dst, input logic [4:0] src);
        return (dst != REG_ZERO) && (dst == src);
    endfunction

endpackage

// File: rtl/id_ex_pipe_if.sv
// ID/EX boundary bundle: decoded instruction and forwarding inputs from ID,
// registered EX-stage view and the load-use freeze back towards IF/ID.
interface id_ex_pipe_if #(
    parameter int DW   = 32,
    parameter int AOPW = 4
);
    logic            id_valid;
    logic [4:0]      id_rs;
    logic [4:0]      id_rt;
    logic [4:0]      id_wnum;
    logic            id_wen;
    logic            id_mem_read;
    logic            id_mem_write;
    logic [AOPW-1:0] id_alu_op;
    logic [DW-1:0]   id_imm;
    logic [DW-1:0]   id_rs_data;
    logic [DW-1:0]   id_rt_data;
    logic [1:0]      rs_select;
    logic [1:0]      rt_select;
    logic [DW-1:0]   exe_fwd_data;
    logic [DW-1:0]   mem_fwd_data;
    logic [DW-1:0]   wb_fwd_data;
    logic            flush;
    logic            ex_stall;
    logic            load_use_stall;
    logic            ex_valid;
    logic [4:0]      ex_rs;
    logic [4:0]      ex_rt;
    logic [4:0]      ex_wnum;
    logic            ex_wen;
    logic            ex_mem_read;
    logic            ex_mem_write;
    logic [AOPW-1:0] ex_alu_op;
    logic [DW-1:0]   ex_rs_val;
    logic [DW-1:0]   ex_rt_val;
    logic [DW-1:0]   ex_imm;

    modport master (
        output id_valid, id_rs, id_rt, id_wnum, id_wen, id_mem_read, id_mem_write,
               id_alu_op, id_imm, id_rs_data, id_rt_data, rs_select, rt_select,
               exe_fwd_data, mem_fwd_data, wb_fwd_data, flush, ex_stall,
        input  load_use_stall, ex_valid, ex_rs, ex_rt, ex_wnum, ex_wen, ex_mem_read,
               ex_mem_write, ex_alu_op, ex_rs_val, ex_rt_val, ex_imm
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_wnum, id_wen, id_mem_read, id_mem_write,
               id_alu_op, id_imm, id_rs_data, id_rt_data, rs_select, rt_select,
               exe_fwd_data, mem_fwd_data, wb_fwd_data, flush, ex_stall,
        output load_use_stall, ex_valid, ex_rs, ex_rt, ex_wnum, ex_wen, ex_mem_read,
               ex_mem_write, ex_alu_op, ex_rs_val, ex_rt_val, ex_imm
    );
endinterface

// File: rtl/operand_fwd_mux.sv
// 4:1 operand source selector (regfile / EXE / MEM / WB); a $0 source always
// takes the register-file value regardless of the requested select.
module operand_fwd_mux
    import mips_pipe_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [4:0]    src_num,
    input  logic [1:0]    sel,
    input  logic [DW-1:0] rf_data,
    input  logic [DW-1:0] exe_data,
    input  logic [DW-1:0] mem_data,
    input  logic [DW-1:0] wb_data,
    output logic [DW-1:0] src_val
);

    logic [1:0] eff_sel_s;

    // Resolve the effective select, then pick the operand source.
    always_comb begin
        eff_sel_s = FWD_RF;
        if (src_num == REG_ZERO) begin
            eff_sel_s = FWD_RF;
        end else begin
            eff_sel_s = sel;
        end

        src_val = rf_data;
        case (eff_sel_s)
            FWD_RF:  src_val = rf_data;
            FWD_EXE: src_val = exe_data;
            FWD_MEM: src_val = mem_data;
            FWD_WB:  src_val = wb_data;
            default: src_val = rf_data;
        endcase
    end

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register: resolves forwarded operands at capture, detects
// load-use hazards (one bubble), holds on EX back-pressure, squashes on flush.
module id_ex_pipe
    import mips_pipe_pkg::*;
#(
    parameter int DW   = 32,
    parameter int AOPW = 4
) (
    input logic         clk,
    input logic         rst_n,
    id_ex_pipe_if.slave bus
);

    logic [DW-1:0]   rs_val_s;
    logic [DW-1:0]   rt_val_s;
    logic            load_use_s;

    logic            ex_valid_r;
    logic [4:0]      ex_rs_r;
    logic [4:0]      ex_rt_r;
    logic [4:0]      ex_wnum_r;
    logic            ex_wen_r;
    logic            ex_mem_read_r;
    logic            ex_mem_write_r;
    logic [AOPW-1:0] ex_alu_op_r;
    logic [DW-1:0]   ex_rs_val_r;
    logic [DW-1:0]   ex_rt_val_r;
    logic [DW-1:0]   ex_imm_r;

    operand_fwd_mux #(.DW(DW)) u_rs_mux (
        .src_num  (bus.id_rs),
        .sel      (bus.rs_select),
        .rf_data  (bus.id_rs_data),
        .exe_data (bus.exe_fwd_data),
        .mem_data (bus.mem_fwd_data),
        .wb_data  (bus.wb_fwd_data),
        .src_val  (rs_val_s)
    );

    operand_fwd_mux #(.DW(DW)) u_rt_mux (
        .src_num  (bus.id_rt),
        .sel      (bus.rt_select),
        .rf_data  (bus.id_rt_data),
        .exe_data (bus.exe_fwd_data),
        .mem_data (bus.mem_fwd_data),
        .wb_data  (bus.wb_fwd_data),
        .src_val  (rt_val_s)
    );

    // Load in EX whose result is needed by the instruction now in ID.
    always_comb begin
        load_use_s = 1'b0;
        if (bus.id_valid && ex_valid_r && ex_mem_read_r && ex_wen_r) begin
            load_use_s = reg_hit(ex_wnum_r, bus.id_rs) || reg_hit(ex_wnum_r, bus.id_rt);
        end else begin
            load_use_s = 1'b0;
        end
    end

    // EX register bank: flush > ex_stall > load-use bubble > capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_r     <= 1'b0;
            ex_rs_r        <= 5'd0;
            ex_rt_r        <= 5'd0;
            ex_wnum_r      <= 5'd0;
            ex_wen_r       <= 1'b0;
            ex_mem_read_r  <= 1'b0;
            ex_mem_write_r <= 1'b0;
            ex_alu_op_r    <= {AOPW{1'b0}};
            ex_rs_val_r    <= {DW{1'b0}};
            ex_rt_val_r    <= {DW{1'b0}};
            ex_imm_r       <= {DW{1'b0}};
        end else if (bus.flush || (!bus.ex_stall && load_use_s)) begin
            // Bubble: data fields are left as-is, controls cleared so nothing forwards from it.
            ex_valid_r     <= 1'b0;
            ex_wen_r       <= 1'b0;
            ex_mem_read_r  <= 1'b0;
            ex_mem_write_r <= 1'b0;
            ex_alu_op_r    <= {AOPW{1'b0}};
        end else if (bus.ex_stall) begin
            ex_valid_r     <= ex_valid_r;
        end else begin
            ex_valid_r     <= bus.id_valid;
            ex_rs_r        <= bus.id_rs;
            ex_rt_r        <= bus.id_rt;
            ex_wnum_r      <= bus.id_wnum;
            ex_wen_r       <= bus.id_valid & bus.id_wen;
            ex_mem_read_r  <= bus.id_valid & bus.id_mem_read;
            ex_mem_write_r <= bus.id_valid & bus.id_mem_write;
            ex_alu_op_r    <= bus.id_valid ? bus.id_alu_op : {AOPW{1'b0}};
            ex_rs_val_r    <= rs_val_s;
            ex_rt_val_r    <= rt_val_s;
            ex_imm_r       <= bus.id_imm;
        end
    end

    assign bus.load_use_stall = load_use_s;
    assign bus.ex_valid       = ex_valid_r;
    assign bus.ex_rs          = ex_rs_r;
    assign bus.ex_rt          = ex_rt_r;
    assign bus.ex_wnum        = ex_wnum_r;
    assign bus.ex_wen         = ex_wen_r;
    assign bus.ex_mem_read    = ex_mem_read_r;
    assign bus.ex_mem_write   = ex_mem_write_r;
    assign bus.ex_alu_op      = ex_alu_op_r;
    assign bus.ex_rs_val      = ex_rs_val_r;
    assign bus.ex_rt_val      = ex_rt_val_r;
    assign bus.ex_imm         = ex_imm_r;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Self-checking bench for id_ex_pipe: directed scenarios plus randomized traffic
// checked against a transaction-level model of the EX stage contents.
module tb_id_ex_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    id_ex_pipe_if #(.DW(32), .AOPW(4)) bus ();

    id_ex_pipe #(.DW(32), .AOPW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wnum;
        logic        wen;
        logic        mr;
        logic        mw;
        logic [3:0]  alu;
        logic [31:0] rsv;
        logic [31:0] rtv;
        logic [31:0] imm;
    } ex_t;

    ex_t m;
    int  n_tests = 0;
    int  n_fail  = 0;

    function automatic logic [31:0] resolve(input logic [4:0] num, input logic [1:0] sel,
                                            input logic [31:0] rf, input logic [31:0] exe,
                                            input logic [31:0] mem, input logic [31:0] wb);
        logic [31:0] src [4];
        src[0] = rf; src[1] = exe; src[2] = mem; src[3] = wb;
        if (num == 5'd0) return rf;
        return src[sel];
    endfunction

    function automatic logic model_lu();
        return bus.id_valid && m.valid && m.mr && m.wen && (m.wnum != 5'd0) &&
               ((m.wnum == bus.id_rs) || (m.wnum == bus.id_rt));
    endfunction

    task automatic set_instr(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] wnum, input logic wen, input logic mr,
                             input logic mw, input logic [3:0] alu, input logic [31:0] imm,
                             input logic [31:0] rsd, input logic [31:0] rtd);
        bus.id_valid = v; bus.id_rs = rs; bus.id_rt = rt; bus.id_wnum = wnum;
        bus.id_wen = wen; bus.id_mem_read = mr; bus.id_mem_write = mw;
        bus.id_alu_op = alu; bus.id_imm = imm; bus.id_rs_data = rsd; bus.id_rt_data = rtd;
    endtask

    task automatic set_fwd(input logic [1:0] rss, input logic [1:0] rts, input logic [31:0] exe,
                           input logic [31:0] mem, input logic [31:0] wb);
        bus.rs_select = rss; bus.rt_select = rts;
        bus.exe_fwd_data = exe; bus.mem_fwd_data = mem; bus.wb_fwd_data = wb;
    endtask

    task automatic set_ctl(input logic fl, input logic st);
        bus.flush = fl; bus.ex_stall = st;
    endtask

    // Advance one clock; the model applies the stage rules to the current ID inputs.
    task automatic tick();
        ex_t nx;
        nx = m;
        if (bus.flush || (!bus.ex_stall && model_lu())) begin
            nx.valid = 1'b0; nx.wen = 1'b0; nx.mr = 1'b0; nx.mw = 1'b0; nx.alu = 4'd0;
        end else if (!bus.ex_stall) begin
            nx.valid = bus.id_valid;
            nx.rs = bus.id_rs; nx.rt = bus.id_rt; nx.wnum = bus.id_wnum;
            nx.wen = bus.id_valid & bus.id_wen;
            nx.mr  = bus.id_valid & bus.id_mem_read;
            nx.mw  = bus.id_valid & bus.id_mem_write;
            nx.alu = bus.id_valid ? bus.id_alu_op : 4'd0;
            nx.rsv = resolve(bus.id_rs, bus.rs_select, bus.id_rs_data, bus.exe_fwd_data,
                             bus.mem_fwd_data, bus.wb_fwd_data);
            nx.rtv = resolve(bus.id_rt, bus.rt_select, bus.id_rt_data, bus.exe_fwd_data,
                             bus.mem_fwd_data, bus.wb_fwd_data);
            nx.imm = bus.id_imm;
        end
        @(posedge clk);
        #1;
        m = nx;
    endtask

    task automatic idle();
        set_ctl(1'b0, 1'b0);
        set_fwd(2'b00, 2'b00, 32'd0, 32'd0, 32'd0);
        set_instr(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0);
        tick();
    endtask

    task automatic test_reset();
        #2;
        n_tests++;
        if ({bus.ex_valid, bus.ex_wen, bus.ex_mem_read, bus.ex_mem_write, bus.ex_wnum,
             bus.ex_rs_val, bus.ex_rt_val, bus.ex_imm, bus.ex_alu_op} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: outputs valid=%b wen=%b rs_val=%h imm=%h, required all 0",
                     bus.ex_valid, bus.ex_wen, bus.ex_rs_val, bus.ex_imm);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m = '0;
        set_instr(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 4'd1, 32'h11, 32'hA, 32'hB);
        tick();
        n_tests++;
        if (bus.ex_valid !== 1'b1 || bus.ex_imm !== 32'h11) begin
            n_fail++;
            $display("FAIL first_capture: valid=%b imm=%h, required 1/00000011", bus.ex_valid, bus.ex_imm);
        end
    endtask

    task automatic test_forward();
        idle();
        set_instr(1'b1, 5'd3, 5'd4, 5'd8, 1'b1, 1'b0, 1'b0, 4'd0, 32'h10, 32'h1111, 32'h2222);
        set_fwd(2'b01, 2'b11, 32'h1234, 32'h9999, 32'hBEEF);
        tick();
        n_tests++;
        if (bus.ex_rs_val !== 32'h1234 || bus.ex_rt_val !== 32'hBEEF || bus.ex_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL forward: rs_val=%h rt_val=%h valid=%b, required 00001234/0000beef/1",
                     bus.ex_rs_val, bus.ex_rt_val, bus.ex_valid);
        end
    endtask

    task automatic test_load_use();
        idle();
        set_instr(1'b1, 5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 4'd0, 32'h4, 32'h100, 32'h0);
        tick();
        set_instr(1'b1, 5'd5, 5'd2, 5'd6, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0, 32'hDEAD, 32'h22);
        set_fwd(2'b01, 2'b00, 32'h104, 32'h0, 32'h0);
        #1;
        n_tests++;
        if (bus.load_use_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL load_use_detect: stall=%b, required 1", bus.load_use_stall);
        end
        tick();
        n_tests++;
        if (bus.ex_valid !== 1'b0 || bus.ex_wen !== 1'b0 || bus.ex_mem_read !== 1'b0) begin
            n_fail++;
            $display("FAIL load_use_bubble: valid=%b wen=%b mr=%b, required 0/0/0",
                     bus.ex_valid, bus.ex_wen, bus.ex_mem_read);
        end
        set_fwd(2'b10, 2'b00, 32'h0, 32'hCAFE0005, 32'h0);
        #1;
        n_tests++;
        if (bus.load_use_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL load_use_once: stall=%b, required 0", bus.load_use_stall);
        end
        tick();
        n_tests++;
        if (bus.ex_valid !== 1'b1 || bus.ex_wnum !== 5'd6 || bus.ex_rs_val !== 32'hCAFE0005 ||
            bus.ex_rt_val !== 32'h22) begin
            n_fail++;
            $display("FAIL load_use_recapture: valid=%b wnum=%0d rs_val=%h rt_val=%h, required 1/6/cafe0005/00000022",
                     bus.ex_valid, bus.ex_wnum, bus.ex_rs_val, bus.ex_rt_val);
        end
    endtask

    task automatic test_zero_reg();
        idle();
        set_instr(1'b1, 5'd0, 5'd9, 5'd0, 1'b1, 1'b1, 1'b0, 4'd0, 32'h0, 32'h55AA, 32'h9);
        set_fwd(2'b01, 2'b00, 32'hFFFF, 32'h0, 32'h0);
        tick();
        n_tests++;
        if (bus.ex_rs_val !== 32'h55AA || bus.ex_mem_read !== 1'b1 || bus.ex_wnum !== 5'd0) begin
            n_fail++;
            $display("FAIL zero_reg_operand: rs_val=%h mr=%b wnum=%0d, required 000055aa/1/0",
                     bus.ex_rs_val, bus.ex_mem_read, bus.ex_wnum);
        end
        set_instr(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0);
        #1;
        n_tests++;
        if (bus.load_use_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_reg_no_stall: stall=%b, required 0", bus.load_use_stall);
        end
        tick();
    endtask

    task automatic test_flush_stall();
        idle();
        set_instr(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 4'd2, 32'h1, 32'h1, 32'h2);
        tick();
        set_instr(1'b1, 5'd4, 5'd5, 5'd6, 1'b1, 1'b0, 1'b1, 4'd3, 32'h2, 32'h3, 32'h4);
        set_ctl(1'b1, 1'b1);
        tick();
        n_tests++;
        if (bus.ex_valid !== 1'b0 || bus.ex_wen !== 1'b0 || bus.ex_mem_write !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_over_stall: valid=%b wen=%b mw=%b, required 0/0/0",
                     bus.ex_valid, bus.ex_wen, bus.ex_mem_write);
        end
        set_ctl(1'b0, 1'b0);
        set_instr(1'b1, 5'd10, 5'd11, 5'd12, 1'b1, 1'b0, 1'b0, 4'd5, 32'hAAAA, 32'hA0A0, 32'hB0B0);
        tick();
        set_ctl(1'b0, 1'b1);
        set_instr(1'b1, 5'd13, 5'd14, 5'd15, 1'b0, 1'b0, 1'b1, 4'd6, 32'hBBBB, 32'hC0C0, 32'hD0D0);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (bus.ex_valid !== 1'b1 || bus.ex_wnum !== 5'd12 || bus.ex_rs_val !== 32'hA0A0 ||
                bus.ex_imm !== 32'hAAAA || bus.ex_alu_op !== 4'd5 || bus.ex_wen !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: valid=%b wnum=%0d rs_val=%h imm=%h, required 1/12/0000a0a0/0000aaaa",
                         i, bus.ex_valid, bus.ex_wnum, bus.ex_rs_val, bus.ex_imm);
            end
        end
        set_ctl(1'b0, 1'b0);
        tick();
        n_tests++;
        if (bus.ex_wnum !== 5'd15 || bus.ex_imm !== 32'hBBBB || bus.ex_mem_write !== 1'b1 ||
            bus.ex_wen !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release: wnum=%0d imm=%h mw=%b wen=%b, required 15/0000bbbb/1/0",
                     bus.ex_wnum, bus.ex_imm, bus.ex_mem_write, bus.ex_wen);
        end
    endtask

    task automatic test_store_hazard();
        idle();
        set_instr(1'b1, 5'd2, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 4'd0, 32'h8, 32'h200, 32'h0);
        tick();
        set_instr(1'b1, 5'd3, 5'd7, 5'd0, 1'b0, 1'b0, 1'b1, 4'd0, 32'h0, 32'h300, 32'h1);
        set_fwd(2'b00, 2'b01, 32'h208, 32'h0, 32'h0);
        #1;
        n_tests++;
        if (bus.load_use_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL store_rt_detect: stall=%b, required 1", bus.load_use_stall);
        end
        tick();
        set_fwd(2'b00, 2'b10, 32'h0, 32'h77770007, 32'h0);
        tick();
        n_tests++;
        if (bus.ex_valid !== 1'b1 || bus.ex_rt_val !== 32'h77770007 || bus.ex_mem_write !== 1'b1 ||
            bus.ex_rs_val !== 32'h300) begin
            n_fail++;
            $display("FAIL store_rt_fwd: valid=%b rt_val=%h mw=%b rs_val=%h, required 1/77770007/1/00000300",
                     bus.ex_valid, bus.ex_rt_val, bus.ex_mem_write, bus.ex_rs_val);
        end
    endtask

    task automatic test_random();
        idle();
        for (int c = 0; c < 400; c++) begin
            set_instr($urandom_range(0, 4) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0,
                      1'($urandom_range(0, 1)), 4'($urandom_range(0, 10)), $urandom, $urandom, $urandom);
            set_fwd(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom);
            set_ctl($urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0);
            #1;
            n_tests++;
            if (bus.load_use_stall !== model_lu()) begin
                n_fail++;
                $display("FAIL rand_stall[%0d]: stall=%b, required %b", c, bus.load_use_stall, model_lu());
            end
            tick();
            n_tests++;
            if (bus.ex_valid !== m.valid || bus.ex_wen !== m.wen || bus.ex_mem_read !== m.mr ||
                bus.ex_mem_write !== m.mw) begin
                n_fail++;
                $display("FAIL rand_ctrl[%0d]: v/wen/mr/mw=%b%b%b%b, required %b%b%b%b", c, bus.ex_valid,
                         bus.ex_wen, bus.ex_mem_read, bus.ex_mem_write, m.valid, m.wen, m.mr, m.mw);
            end
            if (m.valid) begin
                n_tests++;
                if (bus.ex_rs !== m.rs || bus.ex_rt !== m.rt || bus.ex_wnum !== m.wnum ||
                    bus.ex_alu_op !== m.alu || bus.ex_rs_val !== m.rsv || bus.ex_rt_val !== m.rtv ||
                    bus.ex_imm !== m.imm) begin
                    n_fail++;
                    $display("FAIL rand_data[%0d]: rs_val=%h rt_val=%h imm=%h wnum=%0d, required %h/%h/%h/%0d",
                             c, bus.ex_rs_val, bus.ex_rt_val, bus.ex_imm, bus.ex_wnum,
                             m.rsv, m.rtv, m.imm, m.wnum);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        idle();
        set_instr(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 4'd4, 32'h5, 32'h6, 32'h7);
        tick();
        n_tests++;
        if (bus.ex_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_valid: valid=%b, required 1", bus.ex_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.ex_valid, bus.ex_wen, bus.ex_mem_read, bus.ex_wnum, bus.ex_alu_op,
             bus.ex_rs_val, bus.ex_rt_val, bus.ex_imm} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b wen=%b mr=%b rs_val=%h, required all 0",
                     bus.ex_valid, bus.ex_wen, bus.ex_mem_read, bus.ex_rs_val);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m = '0;
        tick();
        n_tests++;
        if (bus.ex_valid !== 1'b1 || bus.ex_imm !== 32'h5 || bus.ex_mem_read !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_capture: valid=%b imm=%h mr=%b, required 1/00000005/1",
                     bus.ex_valid, bus.ex_imm, bus.ex_mem_read);
        end
    endtask

    initial begin
        m = '0;
        set_ctl(1'b0, 1'b0);
        set_fwd(2'b00, 2'b00, 32'd0, 32'd0, 32'd0);
        set_instr(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0);
        test_reset();
        test_forward();
        test_load_use();
        test_zero_reg();
        test_flush_stall();
        test_store_hazard();
        test_random();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
